// File: rtl/cheshire_pkg.sv
// Shared types and constants for the reg-peripheral decode/demux block.
package cheshire_pkg;

    localparam int unsigned RegAddrWidth = 48;
    localparam int unsigned RuleIdxWidth = 32;
    localparam int unsigned ErrCntWidth  = 16;

    // Read data returned for unmapped accesses and for stalled slaves
    localparam logic [31:0] DecodeErrRdata = 32'hBADCAB1E;
    localparam logic [31:0] TimeoutRdata   = 32'hDEADBEEF;

    // One address rule: requests with start <= addr < pte go to slave idx
    typedef struct packed {
        logic [RuleIdxWidth-1:0] idx;
        logic [RegAddrWidth-1:0] start;
        logic [RegAddrWidth-1:0] pte;
    } arul_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_ERR  = 2'd2
    } demux_state_t;

endpackage

// File: rtl/cheshire_reg_rule_match.sv
// Combinational priority matcher: first (lowest-index) rule containing addr wins.
module cheshire_reg_rule_match
    import cheshire_pkg::*;
#(
    parameter int unsigned NumRules = 16
) (
    input  arul_t [NumRules-1:0]     rules,
    input  logic  [RegAddrWidth-1:0] addr,
    output logic                     hit,
    output logic  [RuleIdxWidth-1:0] idx
);

    // Walk from the top rule down so the lowest matching index is the last write.
    // An empty range (start == pte) can never satisfy both compares.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NumRules - 1; i >= 0; i--) begin
            if ((addr >= rules[i].start) && (addr < rules[i].pte)) begin
                hit = 1'b1;
                idx = rules[i].idx;
            end
        end
    end

endmodule

// File: rtl/cheshire_reg_decode_demux.sv
// Reg-bus decoder/demux: latches one upstream request, forwards it to the
// selected slave or answers with an error, and guards slaves with a watchdog.
module cheshire_reg_decode_demux
    import cheshire_pkg::*;
#(
    parameter int unsigned NumOut        = 16,
    parameter int unsigned NumRules      = 16,
    parameter int unsigned AddrWidth     = RegAddrWidth,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  arul_t [NumRules-1:0]          map_i,
    input  logic                          req_valid_i,
    input  logic [AddrWidth-1:0]          req_addr_i,
    input  logic                          req_write_i,
    input  logic [DataWidth-1:0]          req_wdata_i,
    input  logic [DataWidth/8-1:0]        req_wstrb_i,
    output logic                          rsp_ready_o,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic                          rsp_error_o,
    output logic [NumOut-1:0]             out_valid_o,
    output logic [AddrWidth-1:0]          out_addr_o,
    output logic                          out_write_o,
    output logic [DataWidth-1:0]          out_wdata_o,
    output logic [DataWidth/8-1:0]        out_wstrb_o,
    input  logic [NumOut-1:0]             out_ready_i,
    input  logic [NumOut*DataWidth-1:0]   out_rdata_i,
    input  logic [NumOut-1:0]             out_error_i,
    output logic                          timeout_o,
    output logic [ErrCntWidth-1:0]        err_cnt_o
);

    localparam int unsigned SelW = $clog2(NumOut);
    localparam int unsigned WdW  = $clog2(TimeoutCycles + 1);

    demux_state_t                       state;
    logic [SelW-1:0]                    sel;
    logic [WdW-1:0]                     wd_cnt;

    logic                               dec_hit;
    logic [RuleIdxWidth-1:0]            dec_idx;
    logic                               dec_ok;

    logic [NumOut-1:0][DataWidth-1:0]   rdata_arr;
    logic                               sel_ready;
    logic                               wd_expired;

    cheshire_reg_rule_match #(
        .NumRules (NumRules)
    ) i_rule_match (
        .rules (map_i),
        .addr  (RegAddrWidth'(req_addr_i)),
        .hit   (dec_hit),
        .idx   (dec_idx)
    );

    // Index 0 is the internal error slave and is never forwarded to
    assign dec_ok     = dec_hit && (dec_idx != '0) && (dec_idx < RuleIdxWidth'(NumOut));
    assign rdata_arr  = out_rdata_i;
    assign sel_ready  = out_ready_i[sel];
    assign wd_expired = (wd_cnt == WdW'(TimeoutCycles));

    // Response mux: error slave, selected slave pass-through, or watchdog answer
    always_comb begin
        rsp_ready_o = 1'b0;
        rsp_error_o = 1'b0;
        rsp_rdata_o = '0;
        timeout_o   = 1'b0;
        case (state)
            ST_ERR: begin
                rsp_ready_o = 1'b1;
                rsp_error_o = 1'b1;
                rsp_rdata_o = DataWidth'(DecodeErrRdata);
            end
            ST_FWD: begin
                // A slave answering on the expiry cycle still wins
                if (sel_ready) begin
                    rsp_ready_o = 1'b1;
                    rsp_error_o = out_error_i[sel];
                    rsp_rdata_o = rdata_arr[sel];
                end else if (wd_expired) begin
                    rsp_ready_o = 1'b1;
                    rsp_error_o = 1'b1;
                    rsp_rdata_o = DataWidth'(TimeoutRdata);
                    timeout_o   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FSM with request latch, watchdog and saturating error counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            sel         <= '0;
            wd_cnt      <= '0;
            out_valid_o <= '0;
            out_addr_o  <= '0;
            out_write_o <= 1'b0;
            out_wdata_o <= '0;
            out_wstrb_o <= '0;
            err_cnt_o   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        out_addr_o  <= req_addr_i;
                        out_write_o <= req_write_i;
                        out_wdata_o <= req_wdata_i;
                        out_wstrb_o <= req_wstrb_i;
                        sel         <= dec_idx[SelW-1:0];
                        wd_cnt      <= '0;
                        if (dec_ok) begin
                            out_valid_o <= NumOut'(1) << dec_idx[SelW-1:0];
                            state       <= ST_FWD;
                        end else begin
                            state       <= ST_ERR;
                        end
                    end
                end
                ST_ERR: begin
                    if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
                    state <= ST_IDLE;
                end
                ST_FWD: begin
                    if (sel_ready) begin
                        out_valid_o <= '0;
                        state       <= ST_IDLE;
                    end else if (wd_expired) begin
                        out_valid_o <= '0;
                        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cheshire_reg_decode_demux.sv
// Directed bench for the reg decode/demux with a short watchdog.
module tb_cheshire_reg_decode_demux;
    import cheshire_pkg::*;

    localparam int NO = 16;
    localparam int NR = 16;
    localparam int AW = 48;
    localparam int DW = 32;
    localparam int TO = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    arul_t [NR-1:0]       map;
    logic                 req_valid;
    logic [AW-1:0]        req_addr;
    logic                 req_write;
    logic [DW-1:0]        req_wdata;
    logic [DW/8-1:0]      req_wstrb;
    logic                 rsp_ready;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_error;
    logic [NO-1:0]        out_valid;
    logic [AW-1:0]        out_addr;
    logic                 out_write;
    logic [DW-1:0]        out_wdata;
    logic [DW/8-1:0]      out_wstrb;
    logic [NO-1:0]        out_ready;
    logic [NO*DW-1:0]     out_rdata;
    logic [NO-1:0]        out_error;
    logic                 timeout;
    logic [15:0]          err_cnt;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    cheshire_reg_decode_demux #(
        .NumOut(NO), .NumRules(NR), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .map_i(map),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_write_i(req_write),
        .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_ready_o(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
        .out_valid_o(out_valid), .out_addr_o(out_addr), .out_write_o(out_write),
        .out_wdata_o(out_wdata), .out_wstrb_o(out_wstrb),
        .out_ready_i(out_ready), .out_rdata_i(out_rdata), .out_error_i(out_error),
        .timeout_o(timeout), .err_cnt_o(err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_rule(input int r, input int idx, input logic [AW-1:0] s, input logic [AW-1:0] e);
        map[r].idx   = idx;
        map[r].start = s;
        map[r].pte   = e;
    endtask

    task automatic idle_slaves();
        out_ready = '0;
        out_error = '0;
        out_rdata = '0;
    endtask

    task automatic slave(input int s, input logic [DW-1:0] d, input logic er);
        idle_slaves();
        out_ready[s]          = 1'b1;
        out_rdata[s*DW +: DW] = d;
        out_error[s]          = er;
    endtask

    task automatic req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd, input logic [3:0] st);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = wd;
        req_wstrb = st;
    endtask

    // Request that must end in the internal error response one cycle later
    task automatic err_req(input string tag, input logic [AW-1:0] a, input logic [15:0] exp_cnt);
        req(a, 1'b0, '0, '0);
        settle();
        chk({tag, "_c0_vld"}, out_valid, 0);
        tick();
        req_valid = 1'b0;
        settle();
        chk({tag, "_rdy"}, rsp_ready, 1);
        chk({tag, "_err"}, rsp_error, 1);
        chk({tag, "_rdata"}, rsp_rdata, 32'hBADCAB1E);
        chk({tag, "_vld"}, out_valid, 0);
        tick();
        settle();
        chk({tag, "_cnt"}, err_cnt, exp_cnt);
        chk({tag, "_idle_rdy"}, rsp_ready, 0);
    endtask

    // Mapped read where the slave answers in its first valid cycle
    task automatic hit_req(input string tag, input logic [AW-1:0] a, input int s,
                           input logic [NO-1:0] exp_vld, input logic [DW-1:0] d);
        req(a, 1'b0, '0, '0);
        settle();
        tick();
        slave(s, d, 1'b0);
        settle();
        chk({tag, "_vld"}, out_valid, exp_vld);
        chk({tag, "_rdy"}, rsp_ready, 1);
        chk({tag, "_rdata"}, rsp_rdata, d);
        chk({tag, "_err"}, rsp_error, 0);
        req_valid = 1'b0;
        tick();
        idle_slaves();
        settle();
        chk({tag, "_drop"}, out_valid, 0);
        chk({tag, "_norsp"}, rsp_ready, 0);
    endtask

    initial begin
        rst       = 1'b1;
        map       = '0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        req_wstrb = '0;
        idle_slaves();
        set_rule(1, 9,  48'h2000,      48'h3000);
        set_rule(2, 2,  48'h4000,      48'h5000);
        set_rule(3, 3,  48'h0300_0000, 48'h0300_1000);
        set_rule(4, 4,  48'h100,       48'h200);
        set_rule(5, 5,  48'h180,       48'h280);
        set_rule(6, 6,  48'h5000,      48'h5000);
        set_rule(7, 0,  48'h6000,      48'h7000);
        set_rule(8, 20, 48'h7000,      48'h8000);

        // Reset state
        tick();
        tick();
        settle();
        chk("rst_vld", out_valid, 0);
        chk("rst_rdy", rsp_ready, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_to", timeout, 0);
        rst = 1'b0;
        tick();

        // Mapped read, slave 3 answers in its second valid cycle
        req(48'h0300_0004, 1'b0, '0, '0);
        settle();
        chk("rd_c0_vld", out_valid, 0);
        chk("rd_c0_rdy", rsp_ready, 0);
        tick();
        settle();
        chk("rd_c1_vld", out_valid, 16'h0008);
        chk("rd_c1_addr", out_addr, 48'h0300_0004);
        chk("rd_c1_wr", out_write, 0);
        chk("rd_c1_rdy", rsp_ready, 0);
        tick();
        slave(3, 32'h1234, 1'b0);
        settle();
        chk("rd_c2_vld", out_valid, 16'h0008);
        chk("rd_c2_rdy", rsp_ready, 1);
        chk("rd_c2_rdata", rsp_rdata, 32'h1234);
        chk("rd_c2_err", rsp_error, 0);
        req_valid = 1'b0;
        tick();
        idle_slaves();
        settle();
        chk("rd_c3_vld", out_valid, 0);
        chk("rd_c3_rdy", rsp_ready, 0);

        // Unmapped write
        req(48'h0900_0000, 1'b1, 32'hCAFEF00D, 4'hA);
        settle();
        chk("uw_c0_vld", out_valid, 0);
        tick();
        req_valid = 1'b0;
        settle();
        chk("uw_rdy", rsp_ready, 1);
        chk("uw_err", rsp_error, 1);
        chk("uw_rdata", rsp_rdata, 32'hBADCAB1E);
        chk("uw_vld", out_valid, 0);
        chk("uw_wr", out_write, 1);
        chk("uw_wdata", out_wdata, 32'hCAFEF00D);
        chk("uw_wstrb", out_wstrb, 4'hA);
        tick();
        settle();
        chk("uw_cnt", err_cnt, 1);
        chk("uw_idle", rsp_ready, 0);

        // Watchdog expiry on slave 9; a stray ready from slave 3 is ignored
        req(48'h2000, 1'b0, '0, '0);
        settle();
        for (int c = 1; c <= TO; c++) begin
            tick();
            if (c == 4) slave(3, 32'h77, 1'b0);
            else idle_slaves();
            settle();
            chk("to_wait_vld", out_valid, 16'h0200);
            chk("to_wait_rdy", rsp_ready, 0);
            chk("to_wait_to", timeout, 0);
        end
        tick();
        idle_slaves();
        settle();
        chk("to_pulse", timeout, 1);
        chk("to_rdy", rsp_ready, 1);
        chk("to_err", rsp_error, 1);
        chk("to_rdata", rsp_rdata, 32'hDEADBEEF);
        req_valid = 1'b0;
        tick();
        settle();
        chk("to_drop", out_valid, 0);
        chk("to_cnt", err_cnt, 2);
        chk("to_once", timeout, 0);
        tick();
        tick();
        slave(9, 32'h99, 1'b0);
        settle();
        chk("to_late_rdy", rsp_ready, 0);
        chk("to_late_vld", out_valid, 0);
        tick();
        idle_slaves();
        settle();
        chk("to_late_cnt", err_cnt, 2);

        // Ready on the expiry cycle wins over the watchdog
        req(48'h2000, 1'b0, '0, '0);
        settle();
        for (int c = 1; c <= TO; c++) tick();
        tick();
        slave(9, 32'h55, 1'b0);
        settle();
        chk("tie_rdy", rsp_ready, 1);
        chk("tie_rdata", rsp_rdata, 32'h55);
        chk("tie_err", rsp_error, 0);
        chk("tie_to", timeout, 0);
        req_valid = 1'b0;
        tick();
        idle_slaves();
        settle();
        chk("tie_cnt", err_cnt, 2);
        chk("tie_vld", out_valid, 0);

        // Overlap priority and range boundaries
        hit_req("ovl", 48'h190, 4, 16'h0010, 32'hAA);
        hit_req("lo_edge", 48'h1FF, 4, 16'h0010, 32'hBB);
        hit_req("hi_edge", 48'h200, 5, 16'h0020, 32'hCC);
        err_req("empty", 48'h5000, 16'd3);
        err_req("idx0", 48'h6000, 16'd4);
        err_req("idxbig", 48'h7000, 16'd5);
        err_req("pte", 48'h0300_1000, 16'd6);

        // Back-to-back: next request presented during the response cycle
        req(48'h4000, 1'b0, '0, '0);
        settle();
        tick();
        slave(2, 32'h4444, 1'b0);
        settle();
        chk("b2b_c1_vld", out_valid, 16'h0004);
        chk("b2b_c1_rdy", rsp_ready, 1);
        req(48'h0300_0008, 1'b1, 32'h1, 4'hF);
        tick();
        idle_slaves();
        settle();
        chk("b2b_c2_rdy", rsp_ready, 0);
        chk("b2b_c2_vld", out_valid, 0);
        tick();
        settle();
        chk("b2b_c3_vld", out_valid, 16'h0008);
        chk("b2b_c3_addr", out_addr, 48'h0300_0008);
        chk("b2b_c3_wr", out_write, 1);
        slave(3, 32'h0, 1'b0);
        settle();
        chk("b2b_c3_rdy", rsp_ready, 1);
        req_valid = 1'b0;
        tick();
        idle_slaves();
        settle();
        chk("b2b_end_vld", out_valid, 0);

        // Reset during FWD, then the held request decodes normally
        req(48'h190, 1'b0, '0, '0);
        settle();
        tick();
        settle();
        chk("rf_c1_vld", out_valid, 16'h0010);
        rst = 1'b1;
        tick();
        settle();
        chk("rf_vld", out_valid, 0);
        chk("rf_addr", out_addr, 0);
        chk("rf_cnt", err_cnt, 0);
        chk("rf_rdy", rsp_ready, 0);
        rst = 1'b0;
        tick();
        settle();
        chk("rf_re_vld", out_valid, 16'h0010);
        slave(4, 32'hAB, 1'b1);
        settle();
        chk("rf_re_rdy", rsp_ready, 1);
        chk("rf_re_err", rsp_error, 1);
        chk("rf_re_rdata", rsp_rdata, 32'hAB);
        req_valid = 1'b0;
        tick();
        idle_slaves();
        settle();
        chk("rf_end_vld", out_valid, 0);
        chk("rf_end_cnt", err_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
